// File: rtl/alu_pkg.sv
// Shared ALU control codes and the iterative-ALU state encoding.
// The ALU control decoder imports these constants.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } alu_state_e;

endpackage

// File: rtl/mul_div_iter.sv
// Shared shift register datapath for unsigned shift-add multiply and
// restoring divide, one bit per step; {hi, lo} holds product or {remainder, quotient}.
module mul_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div_mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finished,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, opnd_q};
    partial = lo_q[0] ? sum : {1'b0, hi_q};
    // Trial subtraction on {rem, next dividend bit}; MSB set means it went negative.
    trial   = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        hi_step = trial[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_step, lo_step} = {partial, lo_q[WIDTH-1:1]};
    end
  end

  assign finished = step && (cnt_q == CW'(WIDTH - 1));
  assign lo_nxt   = lo_step;
  assign hi_nxt   = hi_step;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (start) begin
      hi_d   = '0;
      lo_d   = div_mode ? a : b;
      opnd_d = div_mode ? b : a;
      div_d  = div_mode;
      cnt_d  = '0;
    end else if (step) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = finished ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_iterativa.sv
// Datapath ALU: single-cycle logic/arith/slt, iterative multiply and divide
// with a start/busy/done handshake; all outputs registered.
module alu_iterativa
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] hi,
  output logic             cero,
  output logic             ocupado,
  output logic             listo,
  output logic             div_cero
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] resultado_q, resultado_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             cero_q, cero_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;
  logic             div_cero_q, div_cero_d;

  logic             md_start, md_mode, md_step, md_finished;
  logic [WIDTH-1:0] md_lo, md_hi;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] c,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    case (c)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      ALU_NOR: return ~(x | y);
      ALU_SLT: return {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: return '0;
    endcase
  endfunction

  mul_div_iter #(
    .WIDTH(WIDTH)
  ) u_mul_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (md_start),
    .div_mode(md_mode),
    .step    (md_step),
    .a       (a),
    .b       (b),
    .finished(md_finished),
    .lo_nxt  (md_lo),
    .hi_nxt  (md_hi)
  );

  always_comb begin
    state_d     = state_q;
    resultado_d = resultado_q;
    hi_d        = hi_q;
    div_cero_d  = div_cero_q;
    md_start    = 1'b0;
    md_mode     = 1'b0;
    md_step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          div_cero_d = 1'b0;
          md_mode    = (control == ALU_DIV);
          if (control == ALU_MUL) begin
            state_d  = MUL;
            md_start = 1'b1;
          end else if (control == ALU_DIV) begin
            if (b != '0) begin
              state_d  = DIV;
              md_start = 1'b1;
            end else begin
              state_d     = DONE;
              resultado_d = '1;
              hi_d        = a;
              div_cero_d  = 1'b1;
            end
          end else begin
            state_d     = DONE;
            resultado_d = alu_single(control, a, b);
          end
        end
      end
      MUL, DIV: begin
        md_step = 1'b1;
        // Results are taken from the final step's next-values so listo lands one edge earlier.
        if (md_finished) begin
          state_d     = DONE;
          resultado_d = md_lo;
          hi_d        = md_hi;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cero_d    = (resultado_d == '0);
    ocupado_d = (state_d == MUL) || (state_d == DIV);
    listo_d   = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      resultado_q <= '0;
      hi_q        <= '0;
      cero_q      <= 1'b1;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
      div_cero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      resultado_q <= resultado_d;
      hi_q        <= hi_d;
      cero_q      <= cero_d;
      ocupado_q   <= ocupado_d;
      listo_q     <= listo_d;
      div_cero_q  <= div_cero_d;
    end
  end

  assign resultado = resultado_q;
  assign hi        = hi_q;
  assign cero      = cero_q;
  assign ocupado   = ocupado_q;
  assign listo     = listo_q;
  assign div_cero  = div_cero_q;

endmodule

// File: tb/tb_alu_iterativa.sv
// Self-checking bench for alu_iterativa: directed cases plus random ops
// against a plain-arithmetic reference model.
module tb_alu_iterativa;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   control = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] resultado, hi;
  logic         cero, ocupado, listo, div_cero;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [W-1:0] model_hi = '0;

  always #5 clk = ~clk;

  alu_iterativa #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .control  (control),
    .a        (a),
    .b        (b),
    .resultado(resultado),
    .hi       (hi),
    .cero     (cero),
    .ocupado  (ocupado),
    .listo    (listo),
    .div_cero (div_cero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_res"},   64'(resultado), 64'd0);
    check({tag, "_hi"},    64'(hi),        64'd0);
    check({tag, "_cero"},  64'(cero),      64'd1);
    check({tag, "_ocup"},  64'(ocupado),   64'd0);
    check({tag, "_listo"}, 64'(listo),     64'd0);
    check({tag, "_dz"},    64'(div_cero),  64'd0);
  endtask

  // Reference semantics straight from the operation table.
  task automatic ref_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic [W-1:0] h,
                        output logic dz, output logic long_op);
    logic [63:0] p;
    r = '0; h = model_hi; dz = 1'b0; long_op = 1'b0;
    case (c)
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0101: r = x ^ y;
      4'b1100: r = ~(x | y);
      4'b0111: r = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = 64'(x) * 64'(y);
        r = p[31:0]; h = p[63:32]; long_op = 1'b1;
      end
      4'b1010: begin
        if (y == 0) begin
          r = 32'hFFFF_FFFF; h = x; dz = 1'b1;
        end else begin
          r = x / y; h = x % y; long_op = 1'b1;
        end
      end
      default: r = '0;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] c,
                        input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    logic [W-1:0] er, eh;
    logic         edz, lng;
    int unsigned  cycles, busy;
    ref_op(c, x, y, er, eh, edz, lng);
    @(negedge clk);
    control = c; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; control = 4'($urandom); a = $urandom; b = $urandom;
    cycles = 1; busy = 0;
    while (!listo && cycles < 100) begin
      if (ocupado) busy++;
      start = (poke && cycles == 5);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, "_lat"},   64'(cycles),    lng ? 64'(W + 1) : 64'd1);
    check({tag, "_busy"},  64'(busy),      lng ? 64'(W) : 64'd0);
    check({tag, "_res"},   64'(resultado), 64'(er));
    check({tag, "_hi"},    64'(hi),        64'(eh));
    check({tag, "_cero"},  64'(cero),      64'(er == 0));
    check({tag, "_dz"},    64'(div_cero),  64'(edz));
    check({tag, "_ocup"},  64'(ocupado),   64'd0);
    model_hi = eh;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(listo),     64'd0);
    check({tag, "_hold"},  64'(resultado), 64'(er));
  endtask

  initial begin
    logic [3:0] codes [12];
    int unsigned listo_seen;
    codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0101,
              4'b1100, 4'b1000, 4'b1010, 4'b0011, 4'b1111, 4'b1010};

    repeat (3) @(posedge clk);
    #1 check_reset_values("rst");
    @(negedge clk) rst_n = 1'b1;

    run_op("add", ALU_ADD, 32'd7, 32'd5, 1'b0);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("sub", ALU_SUB, 32'd5, 32'd5, 1'b0);
    run_op("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_op("div", ALU_DIV, 32'd100, 32'd7, 1'b1);
    run_op("dz",  ALU_DIV, 32'd9, 32'd0, 1'b0);

    // Abort a multiply ten cycles in.
    @(negedge clk);
    control = ALU_MUL; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1 check_reset_values("abort");
    model_hi = '0;
    @(negedge clk) rst_n = 1'b1;
    listo_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (listo) listo_seen++;
    end
    check("abort_nolisto", 64'(listo_seen), 64'd0);
    run_op("add2", ALU_ADD, 32'd1, 32'd1, 1'b0);

    run_op("mulhi", ALU_MUL, 32'd3, 32'd3, 1'b0);
    run_op("undef", 4'b0011, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   c;
      logic [W-1:0] x, y;
      c = codes[$urandom_range(0, 11)];
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 5) == 0) y = '0;
      if ($urandom_range(0, 4) == 0) x = 32'($urandom_range(0, 1000));
      run_op("rnd", c, x, y, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
